lbist_tpg_ps: RTL

- Parametrised LBIST test-pattern generator: an N_LFSR-bit Fibonacci LFSR feeding a generalised XNOR phase shifter that drives N_OUT scan-chain inputs.
- Adds what a pure combinational phase shifter lacks: seed load, pattern counting, a run/done state machine and a ready handshake with the scan-shift controller.
- Sits between the LBIST controller and the scan-chain inputs of the core.

---
 rtl/lbist_tpg_ps.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lbist_tpg_ps.sv
// LBIST test-pattern generator: Fibonacci LFSR + XNOR phase shifter with seed load,
// pattern counting and a ready handshake. Define LBIST_TPG_OUT_REG_EN to register dout_o/valid_o.
module lbist_tpg_ps #(
   parameter int                N_LFSR = 24,
   parameter int                N_OUT  = 267,
   parameter logic [N_LFSR-1:0] POLY   = 24'hE10000,
   parameter logic [N_LFSR-1:0] SEED   = 24'h5A5A5A,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load_i,
   input  logic [N_LFSR-1:0] seed_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  n_patterns_i,
   input  logic              abort_i,
   input  logic              ready_i,
   output logic [N_OUT-1:0]  dout_o,
   output logic              valid_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  pattern_cnt_o,
   output logic [N_LFSR-1:0] lfsr_o
);

   if (N_LFSR < 4 || N_LFSR > 64) begin : g_bad_width
      $error("lbist_tpg_ps: N_LFSR out of range");
   end
   if (N_OUT > (N_LFSR-1)*(1+(N_LFSR+1)/2)) begin : g_bad_nout
      $error("lbist_tpg_ps: N_OUT too large for N_LFSR");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lbist_tpg_ps: SEED must be nonzero");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e            state_q, state_d;
   logic [N_LFSR-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [CNT_W-1:0]  cnt_q, cnt_d, target_q, target_d;
   logic [N_OUT-1:0]  ps_cur;
   logic              accept;

   assign lfsr_step = {lfsr_q[N_LFSR-2:0], ^(lfsr_q & POLY)};

   // Group 0 pairs adjacent bits; later groups pair bit J with an even-spaced anchor bit.
   for (genvar i = 0; i < N_OUT; i++) begin : g_ps
      localparam int G = i / (N_LFSR-1);
      localparam int J = i % (N_LFSR-1);
      localparam int A = (G == 0) ? J + 1 : (2*(G-1)) % N_LFSR;
      assign ps_cur[i] = ~(lfsr_q[J] ^ lfsr_q[A]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED;
         cnt_q    <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
      end
   end

   // The last accept of a run does not step the LFSR, so a restart continues from the last pattern.
   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      if (abort_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (seed_load_i) lfsr_d = (seed_i == '0) ? SEED : seed_i;
               if (start_i) begin
                  cnt_d    = '0;
                  target_d = n_patterns_i;
                  state_d  = (n_patterns_i != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (accept) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == target_q - CNT_W'(1)) state_d = DONE;
                  else lfsr_d = lfsr_step;
               end
            end
            DONE: begin
               if (start_i) begin
                  cnt_d    = '0;
                  target_d = n_patterns_i;
                  state_d  = (n_patterns_i != '0) ? RUN : DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef LBIST_TPG_OUT_REG_EN
   logic [N_OUT-1:0] ps_nxt, dout_q, dout_d;
   logic             valid_q, valid_d;

   for (genvar i = 0; i < N_OUT; i++) begin : g_ps_nxt
      localparam int G = i / (N_LFSR-1);
      localparam int J = i % (N_LFSR-1);
      localparam int A = (G == 0) ? J + 1 : (2*(G-1)) % N_LFSR;
      assign ps_nxt[i] = ~(lfsr_d[J] ^ lfsr_d[A]);
   end

   assign accept = ready_i & valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   // Reload from the post-accept LFSR state so one pattern can be consumed every cycle.
   always_comb begin
      valid_d = (state_q == RUN) && (state_d == RUN);
      dout_d  = dout_q;
      if (valid_d && (!valid_q || accept)) dout_d = ps_nxt;
   end

   assign dout_o  = dout_q;
   assign valid_o = valid_q;
`else
   assign accept  = ready_i & (state_q == RUN);
   assign dout_o  = ps_cur;
   assign valid_o = (state_q == RUN);
`endif

`ifdef LBIST_TPG_OUT_REG_EN
   logic unused_ps;
   assign unused_ps = ^ps_cur;
`endif

   assign busy_o        = (state_q == RUN);
   assign done_o        = (state_q == DONE);
   assign pattern_cnt_o = cnt_q;
   assign lfsr_o        = lfsr_q;

endmodule
